// File: rtl/noc_pkg.sv
// Shared definitions for the PE network interface: flit field offsets and eject verdicts.
// Layout, LSB first: dst_y, dst_x, src_y, src_x, data.
package noc_pkg;

    typedef enum logic [1:0] {
        RX_NONE,
        RX_ACCEPT,
        RX_MISROUTE,
        RX_OVERFLOW
    } rx_verdict_e;

    function automatic int unsigned dst_x_lsb(input int unsigned y_size);
        return y_size;
    endfunction

    function automatic int unsigned src_y_lsb(input int unsigned x_size, input int unsigned y_size);
        return x_size + y_size;
    endfunction

    function automatic int unsigned src_x_lsb(input int unsigned x_size, input int unsigned y_size);
        return x_size + 2 * y_size;
    endfunction

    function automatic int unsigned data_lsb(input int unsigned x_size, input int unsigned y_size);
        return 2 * x_size + 2 * y_size;
    endfunction

endpackage

// File: rtl/noc_pe_interface_if.sv
// Handshake bundle for the PE-side and switch-side links of noc_pe_interface.
// slave is the interface block's view; master is the PE/switch environment.
interface noc_pe_interface_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned X_SIZE     = 2,
    parameter int unsigned Y_SIZE     = 2
);
    localparam int unsigned TOTAL_WIDTH = 2 * X_SIZE + 2 * Y_SIZE + DATA_WIDTH;

    logic                   pe_tx_valid;
    logic                   pe_tx_ready;
    logic [DATA_WIDTH-1:0]  pe_tx_data;
    logic [X_SIZE-1:0]      pe_tx_dst_x;
    logic [Y_SIZE-1:0]      pe_tx_dst_y;

    logic                   sw_tx_valid;
    logic                   sw_tx_ready;
    logic [TOTAL_WIDTH-1:0] sw_tx_data;

    logic                   sw_rx_valid;
    logic                   sw_rx_ready;
    logic [TOTAL_WIDTH-1:0] sw_rx_data;

    logic                   pe_rx_valid;
    logic                   pe_rx_ready;
    logic [DATA_WIDTH-1:0]  pe_rx_data;
    logic [X_SIZE-1:0]      pe_rx_src_x;
    logic [Y_SIZE-1:0]      pe_rx_src_y;

    modport slave (
        input  pe_tx_valid, pe_tx_data, pe_tx_dst_x, pe_tx_dst_y,
        output pe_tx_ready,
        output sw_tx_valid, sw_tx_data,
        input  sw_tx_ready,
        input  sw_rx_valid, sw_rx_data,
        output sw_rx_ready,
        output pe_rx_valid, pe_rx_data, pe_rx_src_x, pe_rx_src_y,
        input  pe_rx_ready
    );

    modport master (
        output pe_tx_valid, pe_tx_data, pe_tx_dst_x, pe_tx_dst_y,
        input  pe_tx_ready,
        input  sw_tx_valid, sw_tx_data,
        output sw_tx_ready,
        output sw_rx_valid, sw_rx_data,
        input  sw_rx_ready,
        input  pe_rx_valid, pe_rx_data, pe_rx_src_x, pe_rx_src_y,
        output pe_rx_ready
    );
endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with registered head; DEPTH must be a power of two so pointers wrap naturally.
module noc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/noc_pe_interface.sv
// Network interface between a mesh switch PE port and its local PE: packs/injects,
// filters/ejects flits, and keeps tx/rx/drop status counters.
module noc_pe_interface
    import noc_pkg::*;
#(
    parameter int unsigned X_COORD     = 0,
    parameter int unsigned Y_COORD     = 0,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned X_SIZE      = 2,
    parameter int unsigned Y_SIZE      = 2,
    parameter int unsigned TOTAL_WIDTH = 2 * X_SIZE + 2 * Y_SIZE + DATA_WIDTH,
    parameter int unsigned TX_DEPTH    = 4,
    parameter int unsigned RX_DEPTH    = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    noc_pe_interface_if.slave     bus,
    output logic [CNT_WIDTH-1:0]  tx_count,
    output logic [CNT_WIDTH-1:0]  rx_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);
    localparam int unsigned RX_WIDTH  = DATA_WIDTH + X_SIZE + Y_SIZE;
    localparam int unsigned DX_LSB    = dst_x_lsb(Y_SIZE);
    localparam int unsigned SY_LSB    = src_y_lsb(X_SIZE, Y_SIZE);
    localparam int unsigned SX_LSB    = src_x_lsb(X_SIZE, Y_SIZE);
    localparam int unsigned D_LSB     = data_lsb(X_SIZE, Y_SIZE);
    localparam logic [X_SIZE-1:0] MY_X = X_SIZE'(X_COORD);
    localparam logic [Y_SIZE-1:0] MY_Y = Y_SIZE'(Y_COORD);

    logic                   tx_full;
    logic                   tx_empty;
    logic                   tx_push;
    logic                   tx_pop;
    logic [TOTAL_WIDTH-1:0] tx_flit;
    logic [TOTAL_WIDTH-1:0] tx_head;

    logic                   rx_full;
    logic                   rx_empty;
    logic                   rx_pop;
    logic                   dst_match;
    logic [RX_WIDTH-1:0]    rx_entry;
    logic [RX_WIDTH-1:0]    rx_head;
    rx_verdict_e            verdict;

    // Inject: pack and buffer; full blocks acceptance even if the head leaves this cycle.
    assign tx_flit         = {bus.pe_tx_data, MY_X, MY_Y, bus.pe_tx_dst_x, bus.pe_tx_dst_y};
    assign bus.pe_tx_ready = !tx_full;
    assign tx_push         = bus.pe_tx_valid && !tx_full;
    assign bus.sw_tx_valid = !tx_empty;
    assign bus.sw_tx_data  = tx_head;
    assign tx_pop          = bus.sw_tx_valid && bus.sw_tx_ready;

    noc_sync_fifo #(.WIDTH(TOTAL_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (tx_push),
        .push_data (tx_flit),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    assign dst_match = (bus.sw_rx_data[DX_LSB +: X_SIZE] == MY_X) &&
                       (bus.sw_rx_data[0 +: Y_SIZE] == MY_Y);
    assign rx_entry  = {bus.sw_rx_data[D_LSB +: DATA_WIDTH],
                        bus.sw_rx_data[SX_LSB +: X_SIZE],
                        bus.sw_rx_data[SY_LSB +: Y_SIZE]};

    // Every presented flit is judged, including ones the switch pushes despite full.
    always_comb begin
        verdict = RX_NONE;
        if (bus.sw_rx_valid) begin
            if (!dst_match)   verdict = RX_MISROUTE;
            else if (rx_full) verdict = RX_OVERFLOW;
            else              verdict = RX_ACCEPT;
        end
    end

    assign bus.sw_rx_ready = !rx_full;
    assign bus.pe_rx_valid = !rx_empty;
    assign rx_pop          = bus.pe_rx_valid && bus.pe_rx_ready;
    assign bus.pe_rx_data  = rx_head[X_SIZE + Y_SIZE +: DATA_WIDTH];
    assign bus.pe_rx_src_x = rx_head[Y_SIZE +: X_SIZE];
    assign bus.pe_rx_src_y = rx_head[0 +: Y_SIZE];

    noc_sync_fifo #(.WIDTH(RX_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (verdict == RX_ACCEPT),
        .push_data (rx_entry),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_count   <= '0;
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (tx_pop) tx_count <= tx_count + 1'b1;
            if (verdict == RX_ACCEPT) rx_count <= rx_count + 1'b1;
            if ((verdict == RX_MISROUTE || verdict == RX_OVERFLOW) && drop_count != '1)
                drop_count <= drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_noc_pe_interface.sv
// Directed bench for noc_pe_interface at node (0,0) with default widths and depths.
module tb_noc_pe_interface;
    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic [15:0] drop_count;
    int          checks   = 0;
    int          failures = 0;
    int          exp_rx   = 0;
    int          exp_drop = 0;

    always #5 clk = ~clk;

    noc_pe_interface_if #(.DATA_WIDTH(8), .X_SIZE(2), .Y_SIZE(2)) bus ();

    noc_pe_interface #(
        .X_COORD(0), .Y_COORD(0), .DATA_WIDTH(8), .X_SIZE(2), .Y_SIZE(2),
        .TX_DEPTH(4), .RX_DEPTH(4), .CNT_WIDTH(16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .tx_count   (tx_count),
        .rx_count   (rx_count),
        .drop_count (drop_count)
    );

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  dx;
        logic [1:0]  dy;
        logic [15:0] flit;
    } inj_vec_t;

    typedef struct {
        logic [15:0] flit;
        logic        push;
        logic [7:0]  data;
        logic [1:0]  sx;
        logic [1:0]  sy;
    } ej_vec_t;

    inj_vec_t inj_tab[5];
    ej_vec_t  ej_tab[6];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] d;

        inj_tab[0] = '{8'hA5, 2'd1, 2'd1, 16'hA505};
        inj_tab[1] = '{8'h00, 2'd0, 2'd0, 16'h0000};
        inj_tab[2] = '{8'hFF, 2'd3, 2'd3, 16'hFF0F};
        inj_tab[3] = '{8'h5A, 2'd2, 2'd1, 16'h5A09};
        inj_tab[4] = '{8'h3C, 2'd0, 2'd3, 16'h3C03};

        // 0x3C04 addresses (1,0), so at node (0,0) it is misrouted.
        ej_tab[0] = '{16'h3C40, 1'b1, 8'h3C, 2'd1, 2'd0};
        ej_tab[1] = '{16'h3C04, 1'b0, 8'h00, 2'd0, 2'd0};
        ej_tab[2] = '{16'h770B, 1'b0, 8'h00, 2'd0, 2'd0};
        ej_tab[3] = '{16'hA5F0, 1'b1, 8'hA5, 2'd3, 2'd3};
        ej_tab[4] = '{16'h0101, 1'b0, 8'h00, 2'd0, 2'd0};
        ej_tab[5] = '{16'h5590, 1'b1, 8'h55, 2'd2, 2'd1};

        rstn = 1'b0;
        bus.pe_tx_valid = 1'b0; bus.pe_tx_data = '0; bus.pe_tx_dst_x = '0; bus.pe_tx_dst_y = '0;
        bus.sw_tx_ready = 1'b0;
        bus.sw_rx_valid = 1'b0; bus.sw_rx_data = '0;
        bus.pe_rx_ready = 1'b0;
        @(negedge clk);
        step();
        step();

        check("rst_sw_tx_valid", 32'(bus.sw_tx_valid), 0);
        check("rst_pe_rx_valid", 32'(bus.pe_rx_valid), 0);
        check("rst_pe_tx_ready", 32'(bus.pe_tx_ready), 1);
        check("rst_sw_rx_ready", 32'(bus.sw_rx_ready), 1);
        check("rst_tx_count", 32'(tx_count), 0);
        check("rst_rx_count", 32'(rx_count), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        rstn = 1'b1;
        step();

        bus.sw_tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.pe_tx_valid = 1'b1;
            bus.pe_tx_data  = inj_tab[i].data;
            bus.pe_tx_dst_x = inj_tab[i].dx;
            bus.pe_tx_dst_y = inj_tab[i].dy;
            check("inj_pe_tx_ready", 32'(bus.pe_tx_ready), 1);
            step();
            bus.pe_tx_valid = 1'b0;
            check("inj_sw_tx_valid", 32'(bus.sw_tx_valid), 1);
            check("inj_sw_tx_data", 32'(bus.sw_tx_data), 32'(inj_tab[i].flit));
            step();
            check("inj_single_cycle", 32'(bus.sw_tx_valid), 0);
            check("inj_tx_count", 32'(tx_count), 32'(i + 1));
        end

        // Backpressure: five offers into a 4-deep FIFO while the switch stalls.
        bus.sw_tx_ready = 1'b0;
        bus.pe_tx_dst_x = 2'd1;
        bus.pe_tx_dst_y = 2'd0;
        for (int k = 0; k < 5; k++) begin
            bus.pe_tx_valid = 1'b1;
            bus.pe_tx_data  = 8'h10 + 8'(k);
            check("bp_pe_tx_ready", 32'(bus.pe_tx_ready), (k < 4) ? 32'd1 : 32'd0);
            step();
        end
        bus.pe_tx_valid = 1'b0;
        check("bp_full_ready", 32'(bus.pe_tx_ready), 0);
        step();
        check("bp_hold_valid", 32'(bus.sw_tx_valid), 1);
        check("bp_hold_data", 32'(bus.sw_tx_data), 32'h1004);
        bus.sw_tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = 8'h10 + 8'(k);
            check("bp_order", 32'(bus.sw_tx_data), 32'({d, 8'h04}));
            step();
            if (k == 0) check("bp_ready_back", 32'(bus.pe_tx_ready), 1);
        end
        check("bp_drained", 32'(bus.sw_tx_valid), 0);
        check("bp_tx_count", 32'(tx_count), 9);

        for (int i = 0; i < 6; i++) begin
            bus.pe_rx_ready = 1'b0;
            bus.sw_rx_valid = 1'b1;
            bus.sw_rx_data  = ej_tab[i].flit;
            step();
            bus.sw_rx_valid = 1'b0;
            if (ej_tab[i].push) exp_rx++;
            else exp_drop++;
            check("ej_pe_rx_valid", 32'(bus.pe_rx_valid), 32'(ej_tab[i].push));
            check("ej_rx_count", 32'(rx_count), 32'(exp_rx));
            check("ej_drop_count", 32'(drop_count), 32'(exp_drop));
            if (ej_tab[i].push) begin
                step();
                check("ej_hold_valid", 32'(bus.pe_rx_valid), 1);
                check("ej_data", 32'(bus.pe_rx_data), 32'(ej_tab[i].data));
                check("ej_src_x", 32'(bus.pe_rx_src_x), 32'(ej_tab[i].sx));
                check("ej_src_y", 32'(bus.pe_rx_src_y), 32'(ej_tab[i].sy));
                bus.pe_rx_ready = 1'b1;
                step();
                bus.pe_rx_ready = 1'b0;
                check("ej_popped", 32'(bus.pe_rx_valid), 0);
            end
        end

        // Overflow: fill the eject FIFO, then the switch ignores backpressure once.
        for (int k = 0; k < 4; k++) begin
            bus.sw_rx_valid = 1'b1;
            bus.sw_rx_data  = {8'h80 + 8'(k), 8'h40};
            check("ov_sw_rx_ready", 32'(bus.sw_rx_ready), 1);
            step();
        end
        exp_rx += 4;
        check("ov_full_ready", 32'(bus.sw_rx_ready), 0);
        bus.sw_rx_data = 16'hEE40;
        step();
        bus.sw_rx_valid = 1'b0;
        exp_drop++;
        check("ov_drop_count", 32'(drop_count), 32'(exp_drop));
        check("ov_rx_count", 32'(rx_count), 32'(exp_rx));
        bus.pe_rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ov_order", 32'(bus.pe_rx_data), 32'(8'h80 + 8'(k)));
            step();
        end
        check("ov_drained", 32'(bus.pe_rx_valid), 0);

        // Reset with three entries buffered on each side.
        bus.pe_rx_ready = 1'b0;
        bus.sw_tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.pe_tx_valid = 1'b1;
            bus.pe_tx_data  = 8'h60 + 8'(k);
            bus.sw_rx_valid = 1'b1;
            bus.sw_rx_data  = {8'h70 + 8'(k), 8'h40};
            step();
        end
        bus.pe_tx_valid = 1'b0;
        bus.sw_rx_valid = 1'b0;
        check("pre_rst_sw_tx_valid", 32'(bus.sw_tx_valid), 1);
        check("pre_rst_pe_rx_valid", 32'(bus.pe_rx_valid), 1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("mid_rst_sw_tx_valid", 32'(bus.sw_tx_valid), 0);
        check("mid_rst_pe_rx_valid", 32'(bus.pe_rx_valid), 0);
        check("mid_rst_pe_tx_ready", 32'(bus.pe_tx_ready), 1);
        check("mid_rst_sw_rx_ready", 32'(bus.sw_rx_ready), 1);
        check("mid_rst_counters", 32'({tx_count, rx_count | drop_count}), 0);
        step();
        check("post_rst_sw_tx_valid", 32'(bus.sw_tx_valid), 0);
        check("post_rst_pe_rx_valid", 32'(bus.pe_rx_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
